// File: rtl/window_reader.sv
// window_reader: walks K x K windows over an IMG_W x IMG_H feature map held in
// a single-port buffer, issuing one read per window element, and streams the
// returned data downstream through a 2-entry FIFO with a valid/ready handshake.
//
// Optional build macro: WINDOW_READER_STRIDE2_EN
//   defined   -> window origins step by 2 (pooling windows)
//   undefined -> window origins step by 1
module window_reader #(
    parameter int BW     = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [BW-1:0]     i_rd_data,
    output logic [BW-1:0]     o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_done
);

`ifdef WINDOW_READER_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif

    // Last legal window origin on each axis (largest multiple of STRIDE that fits).
    localparam int R_LAST = ((IMG_H - K) / STRIDE) * STRIDE;
    localparam int C_LAST = ((IMG_W - K) / STRIDE) * STRIDE;

    localparam logic [ADDR_W-1:0] R_LAST_A = ADDR_W'(R_LAST);
    localparam logic [ADDR_W-1:0] C_LAST_A = ADDR_W'(C_LAST);
    localparam logic [ADDR_W-1:0] K_LAST_A = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              done_q, done_d;

    // Window origin (r, c) and offset inside the window (ky, kx).
    logic [ADDR_W-1:0] r_q, r_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [ADDR_W-1:0] ky_q, ky_d;
    logic [ADDR_W-1:0] kx_q, kx_d;

    // A read issued last cycle whose data arrives this cycle.
    logic              inflight_q;
    logic              inflight_last_q;

    // 2-entry output FIFO.
    logic [1:0][BW-1:0] fifo_data_q;
    logic [1:0]         fifo_last_q;
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         cnt_q, cnt_d;

    logic              push;
    logic              pop;
    logic              issue;
    logic              win_end;
    logic              final_elem;
    logic [2:0]        occ;
    logic [ADDR_W-1:0] origin_step;

    assign push       = inflight_q;
    assign o_valid    = (cnt_q != 2'd0);
    assign pop        = o_valid & i_ready;
    assign o_data     = fifo_data_q[rd_ptr_q];
    assign o_last     = fifo_last_q[rd_ptr_q] & o_valid;
    assign o_done     = done_q;

    // Slots already committed after this cycle's pop; a read may only claim a free slot.
    assign occ        = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    assign issue      = (state_q == S_READ) && (occ < 3'd2) && !i_rst;
    assign o_rd_en    = issue;

    assign win_end    = (ky_q == K_LAST_A) && (kx_q == K_LAST_A);
    assign final_elem = win_end && (c_q == C_LAST_A) && (r_q == R_LAST_A);
    assign o_rd_addr  = (r_q + ky_q) * IMG_W_A + (c_q + kx_q);
    assign cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};

`ifdef WINDOW_READER_STRIDE2_EN
    assign origin_step = ADDR_W'(2);
`else
    assign origin_step = ONE_A;
`endif

    // Next-state for the scan counters: kx fastest, then ky, then c, then r.
    always_comb begin
        r_d  = r_q;
        c_d  = c_q;
        ky_d = ky_q;
        kx_d = kx_q;
        if (issue) begin
            if (kx_q != K_LAST_A) begin
                kx_d = kx_q + ONE_A;
            end else begin
                kx_d = '0;
                if (ky_q != K_LAST_A) begin
                    ky_d = ky_q + ONE_A;
                end else begin
                    ky_d = '0;
                    if (c_q != C_LAST_A) begin
                        c_d = c_q + origin_step;
                    end else begin
                        c_d = '0;
                        if (r_q != R_LAST_A) begin
                            r_d = r_q + origin_step;
                        end else begin
                            r_d = '0;
                        end
                    end
                end
            end
        end
        if (i_rst) begin
            r_d  = '0;
            c_d  = '0;
            ky_d = '0;
            kx_d = '0;
        end
    end

    // Next-state for the control FSM and the sticky done flag.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_READ;
                    done_d  = 1'b0;
                end
            end
            S_READ: begin
                if (issue && final_elem) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once the last element is handed off and nothing is pending.
                if ((cnt_d == 2'd0) && !inflight_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (i_rst) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    // Control state, scan counters and in-flight tracking.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q         <= S_IDLE;
            done_q          <= 1'b0;
            r_q             <= '0;
            c_q             <= '0;
            ky_q            <= '0;
            kx_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            done_q          <= done_d;
            r_q             <= r_d;
            c_q             <= c_d;
            ky_q            <= ky_d;
            kx_q            <= kx_d;
            inflight_q      <= issue;
            inflight_last_q <= issue & win_end;
        end
    end

    // Output FIFO storage; i_rst drops both stored and returning data.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else if (i_rst) begin
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= i_rd_data;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_window_reader.sv
// Testbench for window_reader: behavioural address-list model plus a per-cycle
// checker on the read port and the output stream.
module tb_window_reader;

`ifdef WINDOW_READER_STRIDE2_EN
    localparam int IW  = 5;
    localparam int IH  = 5;
    localparam int STR = 2;
`else
    localparam int IW  = 4;
    localparam int IH  = 4;
    localparam int STR = 1;
`endif
    localparam int KK = 3;
    localparam int BW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          global_rst_n = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_ready = 1'b1;
    logic [BW-1:0] i_rd_data = '0;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [BW-1:0] o_data;
    logic          o_valid;
    logic          o_last;
    logic          o_done;

    window_reader #(
        .BW    (BW),
        .IMG_W (IW),
        .IMG_H (IH),
        .K     (KK),
        .ADDR_W(AW)
    ) dut (
        .clk         (clk),
        .global_rst_n(global_rst_n),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_last      (o_last),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_addr[$];
    int total = 0;
    int iss_idx = 0;
    int pop_idx = 0;
    bit running = 1'b0;
    bit ready_rand = 1'b0;
    int cyc = 0;
    bit seen_valid = 1'b0;
    int first_rd_cyc = 0;
    int last_pop_cyc = 0;
    bit prev_stall = 1'b0;
    logic [BW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected read order straight from the window definition.
    function automatic void build_model();
        exp_addr.delete();
        for (int r = 0; r + KK <= IH; r += STR)
            for (int c = 0; c + KK <= IW; c += STR)
                for (int ky = 0; ky < KK; ky++)
                    for (int kx = 0; kx < KK; kx++)
                        exp_addr.push_back((r + ky) * IW + (c + kx));
        total = exp_addr.size();
    endfunction

    // Buffer model: data equals address, one cycle after the strobe; noise otherwise.
    always @(posedge clk) begin
        if (o_rd_en) i_rd_data <= BW'(o_rd_addr);
        else         i_rd_data <= BW'($urandom);
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle comparison of the read port and output stream against the model.
    always @(negedge clk) begin
        if (running) begin
            if (o_rd_en) begin
                if (iss_idx < total) check("rd_addr", o_rd_addr, exp_addr[iss_idx]);
                else check("extra_rd", 1, 0);
                if (iss_idx == 0) first_rd_cyc = cyc;
                iss_idx++;
            end
            if (prev_stall) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, prev_data);
                check("stall_last", o_last, prev_last);
            end
            check("done", o_done, pop_idx == total);
            if (o_valid && !seen_valid) begin
                seen_valid = 1'b1;
                check("valid_latency", cyc - first_rd_cyc, 2);
            end
            if (o_valid && i_ready) begin
                if (pop_idx < total) begin
                    check("data", o_data, exp_addr[pop_idx] & 8'hff);
                    check("last", o_last, (pop_idx % (KK * KK)) == KK * KK - 1);
                end else begin
                    check("extra_pop", 1, 0);
                end
                pop_idx++;
                last_pop_cyc = cyc;
            end
            check("occupancy", (iss_idx - pop_idx) <= 2, 1);
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end
    end

    task automatic start_run();
        @(posedge clk);
        #1;
        running = 1'b0;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start    = 1'b0;
        iss_idx    = 0;
        pop_idx    = 0;
        seen_valid = 1'b0;
        prev_stall = 1'b0;
        running    = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(pop_idx == total && o_done) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, n < 3000, 1);
    endtask

    task automatic wait_pops(input int cnt);
        int n;
        n = 0;
        while (pop_idx < cnt && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_pops", n < 3000, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, o_rd_en, 0);
        check({tag, "_rd_addr"}, o_rd_addr, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_data"}, o_data, 0);
        check({tag, "_last"}, o_last, 0);
        check({tag, "_done"}, o_done, 0);
    endtask

    initial begin
        build_model();
        // Pin the model with hand-derived values.
`ifdef WINDOW_READER_STRIDE2_EN
        check("model_total", total, 36);
        check("model_win1_first", exp_addr[9], 2);
        check("model_last_first", exp_addr[27], 12);
        check("model_last_mid", exp_addr[31], 18);
        check("model_last_end", exp_addr[35], 24);
`else
        check("model_total", total, 36);
        check("model_w0_3", exp_addr[3], 4);
        check("model_w0_8", exp_addr[8], 10);
        check("model_w1_first", exp_addr[9], 1);
        check("model_w1_end", exp_addr[17], 11);
        check("model_last_first", exp_addr[27], 5);
        check("model_last_end", exp_addr[35], 15);
`endif

        // Asynchronous reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        global_rst_n = 1'b1;

        // Full run at full throughput.
        ready_rand = 1'b0;
        start_run();
        wait_done("timeout_run1");
        check("throughput", last_pop_cyc - first_rd_cyc, total + 1);
        repeat (4) @(negedge clk);
        check("done_sticky", o_done, 1);

        // Random backpressure.
        ready_rand = 1'b1;
        start_run();
        wait_done("timeout_run2");

        // i_start pulse while reading must be ignored.
        start_run();
        wait_pops(5);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done("timeout_run3");
        repeat (5) @(negedge clk);
        check("run3_count", pop_idx, total);

        // Synchronous clear mid-transfer.
        start_run();
        wait_pops(10);
        @(posedge clk);
        #1;
        running = 1'b0;
        i_rst   = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("srst");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("srst_quiet_valid", o_valid, 0);
            check("srst_quiet_rd", o_rd_en, 0);
        end

        // i_rst overrides a simultaneous i_start.
        @(posedge clk);
        #1;
        i_rst   = 1'b1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("override_rd", o_rd_en, 0);
        end

        // Fresh full run after the clear.
        start_run();
        wait_done("timeout_run4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_reader.md
WINDOW_READER -- requirements
Module: window_reader

Interface
REQ-001 SHALL have parameter BW, default 8, meaning the buffer data width.
REQ-002 SHALL have parameter IMG_W, default 28, meaning the feature-map width in elements.
REQ-003 SHALL have parameter IMG_H, default 28, meaning the feature-map height in elements.
REQ-004 SHALL have parameter K, default 5, meaning the square window side.
REQ-005 SHALL have parameter ADDR_W, default 10, meaning the buffer address width.
REQ-006 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-007 SHALL have port global_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_rst, input, 1 bit: synchronous clear.
REQ-009 SHALL have port i_start, input, 1 bit: single-cycle pulse from the buffer writer's done.
REQ-010 SHALL have port o_rd_en, output, 1 bit: buffer read strobe.
REQ-011 SHALL have port o_rd_addr, output, ADDR_W bits: buffer read address.
REQ-012 SHALL have port i_rd_data, input, BW bits: buffer data, valid the cycle after o_rd_en.
REQ-013 SHALL have ports o_data (output, BW), o_valid (output, 1) and i_ready (input, 1): downstream stream handshake.
REQ-014 SHALL have port o_last, output, 1 bit: marks the final element of each window.
REQ-015 SHALL have port o_done, output, 1 bit: sticky completion flag.

Function
REQ-016 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-017 IDLE -> READ SHALL occur on i_start; i_start SHALL be ignored outside IDLE.
REQ-018 READ order SHALL be window origins (r,c) in raster order; within each window ky 0..K-1, then kx 0..K-1; addr = (r+ky)*IMG_W + (c+kx).
REQ-019 Default stride SHALL be 1: r in 0..IMG_H-K, c in 0..IMG_W-K.
REQ-020 Read data SHALL pass through a 2-entry output FIFO.
REQ-021 o_rd_en SHALL assert only when FIFO occupancy + in-flight reads - current pop is < 2; no data SHALL be lost or duplicated.
REQ-022 With i_ready held high, throughput SHALL be one element per cycle; o_valid SHALL rise 2 cycles after the first o_rd_en.
REQ-023 o_data, o_valid and o_last SHALL stay stable while o_valid=1 and i_ready=0.
REQ-024 After the final address is issued, READ -> DRAIN; DRAIN -> IDLE when the FIFO is empty and nothing is in flight.
REQ-025 o_done SHALL set on the IDLE entry cycle from DRAIN and hold until the next accepted i_start or i_rst.
REQ-026 The address arithmetic SHALL be unsigned, computed at ADDR_W bits; IMG_W*IMG_H <= 2^ADDR_W is required.

Reset
REQ-027 global_rst_n low SHALL force IDLE, o_rd_en=0, o_rd_addr=0, o_valid=0, o_data=0, o_last=0, o_done=0, FIFO empty.
REQ-028 i_rst SHALL have the same effect synchronously, override i_start in the same cycle, abort any transfer mid-operation, and discard in-flight read data.

Configuration
REQ-029 Macro WINDOW_READER_STRIDE2_EN defined: window origins SHALL step by 2 (r in 0,2,..<=IMG_H-K; c likewise) for pooling windows.
REQ-030 Macro WINDOW_READER_STRIDE2_EN undefined: stride SHALL be 1, and no stride logic SHALL be synthesized.

Verification (IMG_W=IMG_H=4, K=3 unless stated)
REQ-031 i_start with i_ready=1 -> first window addresses 0,1,2,4,5,6,8,9,10; second window 1,2,3,5,6,7,9,10,11; 36 elements total; o_last on elements 9,18,27,36.
REQ-032 Final window (1,1) -> addresses 5,6,7,9,10,11,13,14,15; o_done rises after the 36th handshake and stays high.
REQ-033 i_ready toggled randomly with i_rd_data=addr -> stream equals the address sequence with no drop/dup; o_data stable while stalled.
REQ-034 i_rst asserted at element 10 -> outputs return to reset values next cycle; a new i_start yields a full 36-element run starting at address 0.
REQ-035 i_start pulsed during READ -> ignored; exactly 36 elements delivered.
REQ-036 WINDOW_READER_STRIDE2_EN defined, IMG_W=IMG_H=5, K=3 -> 4 windows, second window first address 2, last window 12,13,14,17,18,19,22,23,24.
